add_seq: RTL and testbench
==========================

# add_seq

Parametrised, multi-cycle add/subtract unit for the lab datapath, generalising the 4-bit ripple-carry adder to WIDTH bits. It processes CHUNK bits per clock through one chunk adder, so the carry chain length is bounded by CHUNK. It exposes carry, signed-overflow and zero flags behind a valid/ready handshake. It sits between the operand registers and the ALU result mux.

## Interface
- WIDTH, 8: operand/result width; must be ≥2 and a multiple of CHUNK.
- CHUNK, 4: bits summed per cycle; must be ≥1. NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit idle and accepting operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b+ci; 1: a−b (ci ignored).
- ci  in  1  carry-in for add.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum/difference.
- co  out  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  s == 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a and b.
  - Latch b as ~b when sub=1.
  - Latch the carry as 1 when sub=1, otherwise ci.
  - Clear the chunk index and go to CALC.
- CALC:
  - Each cycle, add chunk i (bits i*CHUNK+:CHUNK) with the running carry.
  - Write the chunk into s and store the carry.
  - At i=NCHUNK−1, also capture the carry into the MSB, compute the flags, and go to DONE.
- DONE:
  - out_valid=1; s and flags stay stable.
  - On out_valid&&out_ready, go to IDLE.
- Flags:
  - co = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero is evaluated on the final s.
- Arithmetic is modulo 2^WIDTH unless ADD_SEQ_SAT_EN is defined.
- in_valid is ignored outside IDLE. a, b, sub and ci are sampled only on the accept edge.

## Timing
- Reset values: in_ready=1, out_valid=0, s=0, co=0, ovf=0, zero=0; state IDLE.
- rst has priority over every other input in any state. A reset during CALC or DONE discards the operation, with no result emitted.
- Latency: out_valid rises NCHUNK clocks after the accepting edge (WIDTH=8, CHUNK=4: 2 clocks).
- No overlap. in_ready=0 from the cycle after acceptance until the cycle after the result handshake. Peak throughput is one operation per NCHUNK+2 cycles.
- s and the flags may change during CALC. They are only meaningful while out_valid=1.

## Configuration
- ADD_SEQ_SAT_EN defined:
  - On ovf=1, s clamps to the signed limit: positive overflow gives 0111…1; negative overflow gives 1000…0.
  - Overflow direction follows the sign of the effective A operand.
  - ovf still reports 1, co reports the raw carry, and zero is computed on the clamped s.
- ADD_SEQ_SAT_EN undefined: s wraps; no clamp logic is compiled in.

## Structure
- Package add_seq_pkg holds the state enum typedef (IDLE/CALC/DONE) and a function computing NCHUNK / index width ($clog2, minimum 1).
- Sub-module add_chunk: a combinational CHUNK-bit ripple adder (a, b, ci → s, co, plus c_msb_in, the carry into its top bit). Build it from the existing full-adder cell chain.
- Parameter legality is checked with an elaboration-time assertion.

## Test plan
- WIDTH=8, CHUNK=4: a=8'h3C, b=8'h05, sub=0, ci=1 → s=8'h42, co=0, ovf=0, zero=0; out_valid exactly 2 clocks after accept.
- a=8'hFF, b=8'h01, sub=0, ci=0 → s=8'h00, co=1, ovf=0, zero=1.
- a=8'h7F, b=8'h01, add → ovf=1, s=8'h80 (SAT_EN: s=8'h7F).
- sub cases:
  - a=8'h05, b=8'h07 → s=8'hFE, co=0, ovf=0.
  - a=8'h80, b=8'h01 → ovf=1, co=1, s=8'h7F (SAT_EN: s=8'h80).
- Hold out_ready=0 for 5 cycles while driving new in_valid → s and flags stable, in_ready=0, new operands ignored. Then out_ready=1 → in_ready=1 the next cycle.
- Assert rst for 1 cycle mid-CALC → next cycle in_ready=1, out_valid=0, s=0, all flags 0. A following op (8'h10+8'h20) → s=8'h30.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract unit.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  // Chunk index width; at least one bit even when there is a single chunk.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder made of chained full-adder cells.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // The carry chain is a loop-carried variable rather than a net vector, so
  // there is no self-referencing combinational net.
  always_comb begin
    logic c;
    c        = ci;
    c_msb_in = ci;
    s        = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i == unsigned'(CHUNK - 1)) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, valid/ready on both sides.
// Define ADD_SEQ_SAT_EN to clamp s to the signed limit on overflow.
module add_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = int'(nchunk(WIDTH, CHUNK));
  localparam int IW     = int'(idx_width(NCHUNK));

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("add_seq: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
  end

  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] ca, cb, csum;
  logic             cco, cmsb;
  logic [WIDTH-1:0] s_next, s_fin;
  logic             ovf_next;
  int unsigned      base;

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (ca),
    .b        (cb),
    .ci       (carry),
    .s        (csum),
    .co       (cco),
    .c_msb_in (cmsb)
  );

  always_comb begin
    base     = 32'(idx) * unsigned'(CHUNK);
    ca       = ra[base +: CHUNK];
    cb       = rb[base +: CHUNK];
    s_next   = s;
    s_next[base +: CHUNK] = csum;
    ovf_next = cmsb ^ cco;
    s_fin    = s_next;
`ifdef ADD_SEQ_SAT_EN
    // Direction follows the sign of the (already conditioned) A operand.
    if (ovf_next)
      s_fin = ra[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ra       <= a;
            rb       <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : ci;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          s     <= s_next;
          carry <= cco;
          idx   <= idx + 1'b1;
          if (idx == IW'(NCHUNK - 1)) begin
            s         <= s_fin;
            co        <= cco;
            ovf       <= ovf_next;
            zero      <= (s_fin == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq (WIDTH=8, CHUNK=4); honours ADD_SEQ_SAT_EN.
module tb_add_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, ci;
  logic         out_valid, out_ready, co, ovf, zero;
  logic [W-1:0] a, b, s;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t q[$];
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  add_seq #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a result is consumed on the next rising edge whenever valid&&ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_result", 32'(out_valid), 32'd0);
      end else begin
        res_t e;
        e = q.pop_front();
        check("s",    32'(s),    32'(e.s));
        check("co",   32'(co),   32'(e.co));
        check("ovf",  32'(ovf),  32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zero));
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                       input logic tci, input res_t e, input bit push);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb; sub = tsub; ci = tci; in_valid = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); ci = 1'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!(q.size() == 0 && in_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("done_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [W-1:0] held;
`ifdef ADD_SEQ_SAT_EN
    localparam logic [W-1:0] EXP_7F_ADD = 8'h7F;
    localparam logic [W-1:0] EXP_80_SUB = 8'h80;
`else
    localparam logic [W-1:0] EXP_7F_ADD = 8'h80;
    localparam logic [W-1:0] EXP_80_SUB = 8'h7F;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; ci = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s",         32'(s),         32'd0);
    check("rst_flags",     {29'd0, co, ovf, zero}, 32'd0);

    // 3C + 05 + 1, with latency measurement from the accept edge
    issue(8'h3C, 8'h05, 1'b0, 1'b1, '{s: 8'h42, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'd2);
    wait_done();

    issue(8'hFF, 8'h01, 1'b0, 1'b0, '{s: 8'h00, co: 1'b1, ovf: 1'b0, zero: 1'b1}, 1'b1);
    wait_done();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, '{s: EXP_7F_ADD, co: 1'b0, ovf: 1'b1, zero: 1'b0}, 1'b1);
    wait_done();
    // ci must be ignored for subtraction
    issue(8'h05, 8'h07, 1'b1, 1'b1, '{s: 8'hFE, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b1);
    wait_done();
    issue(8'h80, 8'h01, 1'b1, 1'b0, '{s: EXP_80_SUB, co: 1'b1, ovf: 1'b1, zero: 1'b0}, 1'b1);
    wait_done();

    // Back-pressure: result held while new operands are offered and ignored
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 1'b0, '{s: 8'h46, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_out_valid", 32'(out_valid), 32'd1);
    held = s;
    for (int i = 0; i < 5; i++) begin
      a = 8'hFF; b = 8'hFF; sub = 1'b0; ci = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check("hold_s",        32'(s),        32'h46);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_flags",    {29'd0, co, ovf, zero}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("hold_stable", 32'(s), 32'(held));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("no_ghost_op", 32'(out_valid), 32'd0);

    // Reset mid-CALC discards the operation
    issue(8'h55, 8'h11, 1'b0, 1'b0, '{s: 8'h66, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_s",         32'(s),         32'd0);
    check("mid_rst_flags",     {29'd0, co, ovf, zero}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_discard", 32'(out_valid), 32'd0);
    issue(8'h10, 8'h20, 1'b0, 1'b0, '{s: 8'h30, co: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b1);
    wait_done();

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
